// File: rtl/prf_wr_bank_arbiter_pkg.sv
// Shared sizing, types and helpers for the PRF writeback bank arbiter.
// Bank select is the low PR bits; the remaining upper bits address the row inside a bank.
package prf_wr_bank_arbiter_pkg;
  localparam int PRF_WR_COUNT       = 7;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int LOG_PR_COUNT       = 7;
  localparam int XLEN               = 32;
  localparam int LOG_PRF_WR_COUNT   = 3;
  localparam int UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]     pr_t;
  typedef logic [UPPER_PR_W-1:0]       upper_pr_t;
  typedef logic [XLEN-1:0]             data_t;
  typedef logic [LOG_PRF_WR_COUNT-1:0] wr_idx_t;

  typedef struct packed {
    logic  valid;
    pr_t   pr;
    data_t data;
  } hold_entry_t;

  // Requester index + 1, wrapping at PRF_WR_COUNT (not a power of two).
  function automatic wr_idx_t wr_idx_inc(input wr_idx_t i);
    return (i == wr_idx_t'(PRF_WR_COUNT - 1)) ? '0 : i + wr_idx_t'(1);
  endfunction
endpackage

// File: rtl/prf_wr_bank_arbiter_if.sv
// Writeback requester bus plus per-bank PRF write / completion broadcast.
interface prf_wr_bank_arbiter_if;
  import prf_wr_bank_arbiter_pkg::*;

  logic [PRF_WR_COUNT-1:0]                     req_valid_by_wr;
  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   req_pr_by_wr;
  logic [PRF_WR_COUNT-1:0][XLEN-1:0]           req_data_by_wr;
  logic [PRF_WR_COUNT-1:0]                     req_ready_by_wr;
  logic [PRF_BANK_COUNT-1:0]                   wr_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]   wr_upper_pr_by_bank;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         wr_data_by_bank;
  logic [PRF_BANK_COUNT-1:0]                   complete_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] complete_pr_by_bank;

  modport master (
    output req_valid_by_wr, req_pr_by_wr, req_data_by_wr,
    input  req_ready_by_wr,
    input  wr_valid_by_bank, wr_upper_pr_by_bank, wr_data_by_bank,
    input  complete_valid_by_bank, complete_pr_by_bank
  );

  modport slave (
    input  req_valid_by_wr, req_pr_by_wr, req_data_by_wr,
    output req_ready_by_wr,
    output wr_valid_by_bank, wr_upper_pr_by_bank, wr_data_by_bank,
    output complete_valid_by_bank, complete_pr_by_bank
  );
endinterface

// File: rtl/prf_wr_bank_arbiter_rr_arbiter_n.sv
// Round-robin arbiter: the first requester at or above ptr (wrapping at N) gets a one-hot grant.
module rr_arbiter_n
  import prf_wr_bank_arbiter_pkg::*;
#(
  parameter int N     = PRF_WR_COUNT,
  parameter int PTR_W = LOG_PRF_WR_COUNT
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/prf_wr_bank_arbiter.sv
// Shares the single-write-port PRF banks among the writeback pipes: per-bank round-robin,
// one hold entry per requester, registered bank write with a same-cycle completion broadcast.
module prf_wr_bank_arbiter
  import prf_wr_bank_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  prf_wr_bank_arbiter_if.slave bus
);
  hold_entry_t [PRF_WR_COUNT-1:0]   hold_q, hold_d;
  wr_idx_t     [PRF_BANK_COUNT-1:0] rr_ptr_q, rr_ptr_d;
  logic        [PRF_BANK_COUNT-1:0] wr_valid_q, wr_valid_d;
  upper_pr_t   [PRF_BANK_COUNT-1:0] wr_upper_pr_q, wr_upper_pr_d;
  data_t       [PRF_BANK_COUNT-1:0] wr_data_q, wr_data_d;

  logic  [PRF_WR_COUNT-1:0] cand_valid;
  pr_t   [PRF_WR_COUNT-1:0] cand_pr;
  data_t [PRF_WR_COUNT-1:0] cand_data;
  logic  [PRF_WR_COUNT-1:0] granted;
  logic  [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] bank_req;
  logic  [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0] bank_grant;

  // A held write always presents ahead of a live one so each requester stays in order.
  always_comb begin
    cand_valid = '0;
    cand_pr    = '0;
    cand_data  = '0;
    bank_req   = '0;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      cand_valid[i] = hold_q[i].valid | bus.req_valid_by_wr[i];
      cand_pr[i]    = hold_q[i].valid ? hold_q[i].pr   : bus.req_pr_by_wr[i];
      cand_data[i]  = hold_q[i].valid ? hold_q[i].data : bus.req_data_by_wr[i];
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        bank_req[b][i] = cand_valid[i] &&
                         (cand_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
    rr_arbiter_n #(
      .N     (PRF_WR_COUNT),
      .PTR_W (LOG_PRF_WR_COUNT)
    ) u_rr (
      .req   (bank_req[b]),
      .ptr   (rr_ptr_q[b]),
      .grant (bank_grant[b])
    );
  end

  always_comb begin
    granted = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) granted = granted | bank_grant[b];
  end

  always_comb begin
    bus.req_ready_by_wr = '0;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      bus.req_ready_by_wr[i] = !hold_q[i].valid | granted[i];
    end
  end

  always_comb begin
    hold_d = hold_q;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (hold_q[i].valid) begin
        if (granted[i]) begin
          hold_d[i].valid = bus.req_valid_by_wr[i];
          hold_d[i].pr    = bus.req_pr_by_wr[i];
          hold_d[i].data  = bus.req_data_by_wr[i];
        end
      end else if (bus.req_valid_by_wr[i] && !granted[i]) begin
        hold_d[i].valid = 1'b1;
        hold_d[i].pr    = bus.req_pr_by_wr[i];
        hold_d[i].data  = bus.req_data_by_wr[i];
      end
    end
  end

  always_comb begin
    wr_valid_d    = '0;
    wr_upper_pr_d = '0;
    wr_data_d     = '0;
    rr_ptr_d      = rr_ptr_q;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      wr_valid_d[b] = |bank_grant[b];
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (bank_grant[b][i]) begin
          wr_upper_pr_d[b] = cand_pr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          wr_data_d[b]     = cand_data[i];
          rr_ptr_d[b]      = wr_idx_inc(wr_idx_t'(i));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q        <= '0;
      rr_ptr_q      <= '0;
      wr_valid_q    <= '0;
      wr_upper_pr_q <= '0;
      wr_data_q     <= '0;
    end else begin
      hold_q        <= hold_d;
      rr_ptr_q      <= rr_ptr_d;
      wr_valid_q    <= wr_valid_d;
      wr_upper_pr_q <= wr_upper_pr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  always_comb begin
    bus.wr_valid_by_bank       = wr_valid_q;
    bus.wr_upper_pr_by_bank    = wr_upper_pr_q;
    bus.wr_data_by_bank        = wr_data_q;
    bus.complete_valid_by_bank = wr_valid_q;
    bus.complete_pr_by_bank    = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      bus.complete_pr_by_bank[b] = {wr_upper_pr_q[b], LOG_PRF_BANK_COUNT'(b)};
    end
  end
endmodule

// File: tb/tb_prf_wr_bank_arbiter.sv
// Directed bench for prf_wr_bank_arbiter: per-bank scoreboard queues filled at issue,
// drained by a negedge monitor whenever a bank write appears.
module tb_prf_wr_bank_arbiter;
  import prf_wr_bank_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prf_wr_bank_arbiter_if bus ();

  prf_wr_bank_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    upper_pr_t upper;
    data_t     data;
    pr_t       cpr;
  } exp_t;

  exp_t sb_q [PRF_BANK_COUNT][$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int b, input pr_t pr, input data_t d);
    exp_t e;
    e.upper = pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
    e.data  = d;
    e.cpr   = pr;
    sb_q[b].push_back(e);
  endtask

  always @(negedge clk) begin
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (bus.wr_valid_by_bank[b] || bus.complete_valid_by_bank[b])
        chk($sformatf("complete_valid_mirror_b%0d", b),
            64'(bus.complete_valid_by_bank[b]), 64'(bus.wr_valid_by_bank[b]));
      if (bus.wr_valid_by_bank[b]) begin
        if (sb_q[b].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write bank=%0d actual_upper=%0h actual_data=%0h required=none",
                   b, bus.wr_upper_pr_by_bank[b], bus.wr_data_by_bank[b]);
        end else begin
          mon_e = sb_q[b].pop_front();
          chk($sformatf("wr_upper_pr_b%0d", b), 64'(bus.wr_upper_pr_by_bank[b]), 64'(mon_e.upper));
          chk($sformatf("wr_data_b%0d", b), 64'(bus.wr_data_by_bank[b]), 64'(mon_e.data));
          chk($sformatf("complete_pr_b%0d", b), 64'(bus.complete_pr_by_bank[b]), 64'(mon_e.cpr));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req_valid_by_wr = '0;
    bus.req_pr_by_wr    = '0;
    bus.req_data_by_wr  = '0;
  endtask

  task automatic set_req(input int i, input pr_t pr, input data_t d);
    bus.req_valid_by_wr[i] = 1'b1;
    bus.req_pr_by_wr[i]    = pr;
    bus.req_data_by_wr[i]  = d;
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    next_slot();
    rst = 1'b0;
  endtask

  function automatic pr_t rr_pr(input int r, input int n);
    return pr_t'(r * 16 + n * 4);
  endfunction

  function automatic data_t rr_data(input int r, input int n);
    return data_t'(32'h1000_0000 + r * 256 + n);
  endfunction

  initial begin
    int n1, n4;
    logic [PRF_WR_COUNT-1:0] exp_rdy;

    // reset held two cycles while every requester is asserting
    rst = 1'b1;
    for (int i = 0; i < PRF_WR_COUNT; i++) set_req(i, pr_t'(4 * i + 1), data_t'(i));
    next_slot();
    @(negedge clk);
    chk("rst_wr_valid", 64'(bus.wr_valid_by_bank), 64'h0);
    chk("rst_complete_valid", 64'(bus.complete_valid_by_bank), 64'h0);
    chk("rst_ready", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("post_rst_wr_valid", 64'(bus.wr_valid_by_bank), 64'h0);
    chk("post_rst_ready", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    @(negedge clk);
    chk("post_rst_wr_valid2", 64'(bus.wr_valid_by_bank), 64'h0);
    next_slot();

    // disjoint banks in a single cycle
    for (int i = 0; i < 4; i++) begin
      set_req(i, pr_t'(4 + i), data_t'(32'hA000_0000 + i));
      push_exp(i, pr_t'(4 + i), data_t'(32'hA000_0000 + i));
    end
    @(negedge clk);
    chk("disjoint_ready_issue", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    idle_inputs();
    @(negedge clk);
    chk("disjoint_wr_valid", 64'(bus.wr_valid_by_bank), 64'hF);
    chk("disjoint_ready_after", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    @(negedge clk);
    chk("disjoint_wr_valid_done", 64'(bus.wr_valid_by_bank), 64'h0);
    next_slot();

    // all seven requesters on bank 2
    reset_dut();
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      set_req(i, pr_t'(4 * i + 2), data_t'(32'hC000_0000 + i));
      push_exp(2, pr_t'(4 * i + 2), data_t'(32'hC000_0000 + i));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0 || k == 7) exp_rdy = 7'h7F;
      else exp_rdy = 7'((1 << (k + 1)) - 1);
      chk($sformatf("conflict_ready_s%0d", k), 64'(bus.req_ready_by_wr), 64'(exp_rdy));
      if (k >= 1) chk($sformatf("conflict_wr_valid2_s%0d", k), 64'(bus.wr_valid_by_bank[2]), 64'h1);
      next_slot();
      if (k == 0) idle_inputs();
    end
    @(negedge clk);
    chk("conflict_wr_valid2_done", 64'(bus.wr_valid_by_bank[2]), 64'h0);
    next_slot();

    // wr1 and wr4 streaming onto bank 0 must alternate
    reset_dut();
    for (int n = 0; n < 5; n++) begin
      push_exp(0, rr_pr(1, n), rr_data(1, n));
      push_exp(0, rr_pr(4, n), rr_data(4, n));
    end
    n1 = 0;
    n4 = 0;
    for (int s = 0; s < 10; s++) begin
      idle_inputs();
      if (s < 8) begin
        set_req(1, rr_pr(1, n1), rr_data(1, n1));
        set_req(4, rr_pr(4, n4), rr_data(4, n4));
      end
      @(negedge clk);
      if (s < 8) begin
        chk($sformatf("rr_ready1_s%0d", s), 64'(bus.req_ready_by_wr[1]),
            (s < 2 || s % 2 == 0) ? 64'h1 : 64'h0);
        chk($sformatf("rr_ready4_s%0d", s), 64'(bus.req_ready_by_wr[4]),
            (s < 2 || s % 2 == 1) ? 64'h1 : 64'h0);
        if (bus.req_ready_by_wr[1]) n1++;
        if (bus.req_ready_by_wr[4]) n4++;
      end
      next_slot();
    end
    chk("rr_wr1_transfers", 64'(n1), 64'd5);
    chk("rr_wr4_transfers", 64'(n4), 64'd5);
    idle_inputs();
    repeat (2) next_slot();

    // held wr3 issues a newer bank-1 write on its grant cycle
    reset_dut();
    push_exp(1, pr_t'(7'h01), data_t'(32'hD000_0000));
    push_exp(1, pr_t'(7'h0D), data_t'(32'hD000_003A));
    push_exp(1, pr_t'(7'h15), data_t'(32'hD000_0005));
    push_exp(1, pr_t'(7'h11), data_t'(32'hD000_003B));
    set_req(0, pr_t'(7'h01), data_t'(32'hD000_0000));
    set_req(3, pr_t'(7'h0D), data_t'(32'hD000_003A));
    @(negedge clk);
    chk("hold_ready_s0", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    idle_inputs();
    set_req(3, pr_t'(7'h11), data_t'(32'hD000_003B));
    set_req(5, pr_t'(7'h15), data_t'(32'hD000_0005));
    @(negedge clk);
    chk("hold_ready_s1", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    idle_inputs();
    @(negedge clk);
    chk("hold_ready_s2", 64'(bus.req_ready_by_wr), 64'h77);
    next_slot();
    @(negedge clk);
    chk("hold_ready_s3", 64'(bus.req_ready_by_wr), 64'h7F);
    repeat (3) next_slot();

    // reset with three writes held on bank 3 discards them
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, pr_t'(4 * i + 3), data_t'(32'hE000_0000 + i));
    push_exp(3, pr_t'(7'h03), data_t'(32'hE000_0000));
    @(negedge clk);
    chk("midrst_ready_s0", 64'(bus.req_ready_by_wr), 64'h7F);
    next_slot();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready_held", 64'(bus.req_ready_by_wr), 64'h73);
    next_slot();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(bus.req_ready_by_wr), 64'h7F);
    chk("midrst_wr_valid_after", 64'(bus.wr_valid_by_bank), 64'h0);
    for (int k = 0; k < 3; k++) begin
      next_slot();
      @(negedge clk);
      chk($sformatf("midrst_no_write_%0d", k), 64'(bus.wr_valid_by_bank), 64'h0);
    end
    next_slot();

    for (int b = 0; b < PRF_BANK_COUNT; b++)
      chk($sformatf("sb_drained_b%0d", b), 64'(sb_q[b].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
